// File: rtl/instruction_queue_pkg.sv
// ============================================================================
// Module   : instruction_queue_pkg
// Purpose  : Shared sizing constants and types for the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_queue_pkg;

  // Queue depth and pointer width; depth must stay a power of two so the
  // pointers can wrap naturally.
  localparam int ISQ_SIZE   = 16;
  localparam int ISQ_ADDR_W = 4;

  // Legacy boolean aliases shared with the rest of the pipeline.
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // One 32-bit instruction or program-counter word.
  typedef logic [31:0] word_t;

endpackage : instruction_queue_pkg

`default_nettype wire

// File: rtl/instruction_queue.sv
// ============================================================================
// Module   : instruction_queue
// Purpose  : Circular show-ahead FIFO between instruction fetch and issue.
//            The head entry is presented combinationally; it issues on any
//            cycle in which no downstream unit is full. roll_back empties the
//            queue in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int ISQ_SIZE = instruction_queue_pkg::ISQ_SIZE,
  parameter int ADDR_W   = instruction_queue_pkg::ISQ_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic              if_valid,
  input  logic [31:0]       if_ins,
  input  logic [31:0]       if_pc,
  output logic              isq_full,
  input  logic              rob_is_full,
  input  logic              rs_is_full,
  input  logic              lsb_is_full,
  output logic              get_instruction,
  output logic [31:0]       isq_ins_out,
  output logic [31:0]       isq_pc_out,
  output logic [ADDR_W:0]   isq_count
);

  localparam logic [ADDR_W:0]   C_FULL_COUNT = (ADDR_W+1)'(ISQ_SIZE);
  localparam logic [ADDR_W-1:0] C_PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  // Entry storage; contents are never reset and may go stale after a flush.
  word_t ins_q [ISQ_SIZE];
  word_t pc_q  [ISQ_SIZE];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic push_w;
  logic issue_w;
  logic downstream_busy_w;

  // Full/empty decisions come from the occupancy counter alone; head == tail
  // is ambiguous once the queue has wrapped.
  assign isq_full          = (count_q == C_FULL_COUNT);
  assign isq_count         = count_q;
  assign downstream_busy_w = rob_is_full | rs_is_full | lsb_is_full;

  // Full does not look ahead to a same-cycle pop, so a push at full is refused
  // even when the head is issuing.
  assign push_w  = rdy_in & ~roll_back & if_valid & ~isq_full;
  assign issue_w = rdy_in & ~roll_back & (count_q != '0) & ~downstream_busy_w;

  assign get_instruction = issue_w;
  assign isq_ins_out     = ins_q[head_q];
  assign isq_pc_out      = pc_q[head_q];

  // Next-state pointers and occupancy; roll_back wins over everything,
  // including a paused pipeline.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (roll_back) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_w) begin
        tail_d = tail_q + C_PTR_ONE;
      end
      if (issue_w) begin
        head_d = head_q + C_PTR_ONE;
      end
      unique case ({push_w, issue_w})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the fetched pair into the tail slot on an accepted push.
  always_ff @(posedge clk_in) begin
    if (push_w == TRUE) begin
      ins_q[tail_q] <= if_ins;
      pc_q[tail_q]  <= if_pc;
    end
  end

endmodule : instruction_queue

`default_nettype wire

// File: doc/instruction_queue.md
# instruction_queue

Circular show-ahead FIFO between instruction fetch and the issue stage. Fetch pushes one `{instruction, pc}` pair per cycle. The queue presents its head entry combinationally to the decoder and reorder buffer, and pops it on any cycle in which no downstream unit is full. On `roll_back` the queue flushes completely in one cycle.

## Interface
- `ISQ_SIZE`, 16: entry count; must be a power of two.
- `ADDR_W`, 4: log2(`ISQ_SIZE`).

- `clk_in` in 1: system clock, rising-edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: pause when low.
- `roll_back` in 1: mispredict flush.
- `if_valid` in 1: fetch offers an entry this cycle.
- `if_ins` in 32: fetched instruction.
- `if_pc` in 32: pc of the fetched instruction.
- `isq_full` out 1: high when count == `ISQ_SIZE`; fetch must not assert `if_valid` while it is high.
- `rob_is_full` in 1: reorder buffer cannot accept.
- `rs_is_full` in 1: reservation station cannot accept.
- `lsb_is_full` in 1: load/store buffer cannot accept.
- `get_instruction` out 1: head entry issued this cycle.
- `isq_ins_out` out 32: head instruction.
- `isq_pc_out` out 32: head pc.
- `isq_count` out `ADDR_W+1`: occupancy, 0..`ISQ_SIZE`.

## Operation
- Storage: `ins[ISQ_SIZE]`, `pc[ISQ_SIZE]`, plus `head`, `tail` (`ADDR_W` bits, wrap modulo `ISQ_SIZE`) and `count` (`ADDR_W+1` bits).
- Full and empty are decided by `count` only, never by `head == tail`.
- Push condition: `push = rdy_in & !roll_back & if_valid & !isq_full`.
  - Effect: write `ins[tail]` and `pc[tail]`, then `tail <= tail+1`.
  - `if_valid` while `isq_full` is dropped; fetch is responsible for holding it.
- Issue condition: `get_instruction = rdy_in & !roll_back & (count != 0) & !rob_is_full & !rs_is_full & !lsb_is_full`. This is combinational.
  - `isq_ins_out` and `isq_pc_out` always equal `ins[head]` and `pc[head]`. Their value is don't-care when `count == 0`.
  - On issue, `head <= head+1`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Full with a simultaneous pop: the push is still refused, because `isq_full` does not look ahead to the pop.
- Empty with a simultaneous push: there is no bypass and no issue; the pushed entry becomes issuable the next cycle.
- `roll_back` (sampled when `rdy_in` is high or low):
  - At the next edge: `head`, `tail`, `count` all go to 0.
  - Push and issue are suppressed in that same cycle.
  - Array contents are left stale.
- `rdy_in` low: all state is frozen and `get_instruction` is 0.
- Reset (`rst_in` low, asynchronous):
  - `head`, `tail`, `count` go to 0.
  - Outputs: `get_instruction` = 0, `isq_full` = 0, `isq_count` = 0. `isq_ins_out` and `isq_pc_out` are don't-care.
  - Array contents do not need to be reset.

## Timing
- Push accepted at edge t → entry issuable in cycle t+1. Minimum fetch-to-issue latency is 1 cycle.
- Throughput: 1 push and 1 issue per cycle, sustained.
- `isq_full` and `isq_count` are registered-state decodes and change only after an edge.
- Downstream full flags are consumed in the same cycle.
  - The reorder buffer samples `get_instruction` on the same edge that advances `head`.
  - Its full flag therefore reflects the issue by the following cycle, and no over-issue is possible.
- Roll_back asserted at edge t: `count == 0` and `get_instruction == 0` from t+1 onward until a new push lands.
- Reset release is asynchronous. The first push takes effect on the first clock edge at which `rst_in` is high.

## Structure
- Shared definitions file (`operaType.v`) gains `ISQ_SIZE` and `ISQ_ADDR_W`. The existing `TRUE`/`FALSE` defines are reused.
- Single module with no submodule.
- Pointer arithmetic relies on natural `ADDR_W`-bit wrap.

## Test plan
- Reset with `rst_in` low mid-cycle → `isq_count`=0 and `get_instruction`=0 immediately, with no clock edge needed.
- Push `ins=0x00500093`, `pc=0x0` into an empty queue with downstream not full → `get_instruction`=1 the next cycle with exact data; `count` returns 0 after that issue.
- Push 16 entries with `rob_is_full`=1 → `isq_full`=1 and `count`=16; a 17th `if_valid` is dropped. Release `rob_is_full` → entries issue in push order, pc 0x0..0x3C, and the pointers wrap.
- Steady state: `count`=5 with a push and an issue every cycle for 20 cycles → `count` stays 5 and data order is preserved across the wrap.
- `roll_back` with `count`=9 and `if_valid`=1 → no push and no issue that cycle; `count`=0 and `get_instruction`=0 on the next cycle.
- `rdy_in`=0 for 3 cycles with `count`=4 and `if_valid`=1 → no state change and `get_instruction`=0; resumes issuing the same head entry when `rdy_in` returns high.
